audio_in_deserializer: RTL and testbench
========================================

AUDIO_IN_DESERIALIZER -- requirements
Module: audio_in_deserializer

Interface
REQ-001 Parameter DATA_WIDTH, default 32, is the bits captured per channel word.
REQ-002 Parameter FIFO_DEPTH, default 8 (power of 2), is the stereo-pair FIFO capacity.
REQ-003 clk  input  1  system clock (CLOCK_50 domain); one clock; all logic on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 AUD_BCLK  input  1  codec bit clock, asynchronous to clk.
REQ-006 AUD_ADCLRCK  input  1  codec ADC frame clock (low = left, high = right), asynchronous.
REQ-007 AUD_ADCDAT  input  1  codec ADC serial data, I2S format, MSB first.
REQ-008 read_audio_in  input  1  consumer pop strobe, one pair per asserted cycle.
REQ-009 clear_audio_in_memory  input  1  synchronous FIFO flush.
REQ-010 audio_in_available  output  1  FIFO non-empty.
REQ-011 left_channel_audio_in  output  DATA_WIDTH  head-of-FIFO left word (show-ahead).
REQ-012 right_channel_audio_in  output  DATA_WIDTH  head-of-FIFO right word (show-ahead).
REQ-013 fifo_used  output  log2(FIFO_DEPTH)+1  pairs currently stored.
REQ-014 overflow  output  1  sticky: a completed pair was dropped because FIFO was full.

Function
REQ-015 BCLK, ADCLRCK, ADCDAT SHALL each pass a 2-flop synchronizer; edges SHALL be detected from the synchronized value and its 1-cycle delayed copy.
REQ-016 On any synchronized LRCK edge the bit counter SHALL reset to 0 and the shift register SHALL clear.
REQ-017 The first BCLK rising edge after an LRCK edge SHALL be ignored (I2S one-bit delay).
REQ-018 The next DATA_WIDTH BCLK rising edges SHALL shift ADCDAT into the shift register MSB first; further edges in the same half-frame SHALL be ignored.
REQ-019 A half-frame with fewer than DATA_WIDTH bits SHALL yield a left-aligned word, unreceived LSBs zero.
REQ-020 On LRCK rising edge the shift register SHALL latch into a left holding register and set left_valid.
REQ-021 On LRCK falling edge, if left_valid, the pair {left holding, shift register} SHALL be pushed in that same cycle and left_valid cleared; if not left_valid, nothing is pushed.
REQ-022 audio_in_available, data outputs and fifo_used SHALL reflect a push on the cycle after the push.
REQ-023 Pop when empty SHALL be ignored; fifo_used never underflows.
REQ-024 Push when full without a simultaneous pop SHALL drop the new pair and set overflow; stored data unchanged.
REQ-025 Simultaneous push and pop when full SHALL succeed; fifo_used stays FIFO_DEPTH; overflow unchanged.
REQ-026 Simultaneous push and pop when non-full, non-empty SHALL leave fifo_used unchanged.
REQ-027 Read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 clear_audio_in_memory SHALL empty the FIFO and clear overflow next cycle, overriding same-cycle push and pop; the deserializer state is not affected.
REQ-029 Data outputs SHALL be zero while FIFO is empty.

Reset
REQ-030 reset_n low SHALL immediately force: FIFO empty, fifo_used 0, audio_in_available 0, data outputs 0, overflow 0, left_valid 0, bit counter 0, shift register 0, synchronizers 0.
REQ-031 Reset mid-frame SHALL discard the partial frame; the first pushed pair after release SHALL come from a full left-then-right sequence.

Structure
REQ-032 DATA_WIDTH and FIFO_DEPTH defaults and the pointer-width derivation SHALL live in the shared audio package.
REQ-033 The FIFO SHALL be one sub-module, audio_pair_fifo (width 2*DATA_WIDTH, show-ahead, count output); synchronizers and deserializer stay in this module.

Verification
REQ-034 BCLK=clk/16, DATA_WIDTH 32: send L=32'h8000_0001, R=32'h7FFF_FFFE -> one push; outputs show exactly those values, fifo_used=1.
REQ-035 Start stimulus with LRCK high (mid right half-frame) -> no push until a complete left then right frame; first pair correct.
REQ-036 Push 9 pairs with no pops (depth 8) -> fifo_used=8, overflow=1, head is pair 1, pair 9 lost; pops return pairs 1..8.
REQ-037 With FIFO full, assert read_audio_in in the push cycle -> fifo_used stays 8, overflow stays 0, head advances.
REQ-038 Half-frames of 24 BCLKs, L bits all ones -> left = 32'hFFFF_FF00.
REQ-039 Assert clear_audio_in_memory with 3 stored pairs and a simultaneous push -> next cycle fifo_used=0, available=0, overflow=0; reset_n pulse mid-word -> all outputs 0 immediately.

Source files
------------

// File: rtl/audio_in_deserializer_pkg.sv
// Shared defaults, codec pin bundle and width helpers for the audio-in path.
package audio_in_deserializer_pkg;

  localparam int AUDIO_DATA_WIDTH = 32;
  localparam int AUDIO_FIFO_DEPTH = 8;

  typedef struct packed {
    logic bclk;
    logic lrck;
    logic dat;
  } codec_pins_t;

  // FIFO depth is a power of two, so the pointer is log2(depth) bits and wraps naturally.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Bit counter must reach DATA_WIDTH+1 so it can park after the last captured bit.
  function automatic int bit_cnt_width(input int data_width);
    return $clog2(data_width + 2);
  endfunction

endpackage

// File: rtl/audio_pair_fifo.sv
// Show-ahead stereo-pair FIFO with occupancy count and sticky drop flag.
// Push visible next cycle; push when full without a pop is dropped and sets overflow.
module audio_pair_fifo
  import audio_in_deserializer_pkg::*;
#(
  parameter int WIDTH = 2 * AUDIO_DATA_WIDTH,
  parameter int DEPTH = AUDIO_FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        clear,
  input  logic                        push,
  input  logic [WIDTH-1:0]            push_data,
  input  logic                        pop,
  output logic [WIDTH-1:0]            head_data,
  output logic                        available,
  output logic [ptr_width(DEPTH):0]   count,
  output logic                        overflow
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             empty;
  logic             full;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot the write lands in, so full+pop still accepts.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + (PTR_W + 1)'(do_push) - (PTR_W + 1)'(do_pop);
      if (push && !do_push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

  assign available = ~empty;
  assign head_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/audio_in_deserializer.sv
// I2S ADC capture: synchronizes codec pins, deserializes left/right words, queues stereo pairs.
// A pair is visible one clk after the LRCK fall that closes it; a full FIFO drops it and flags overflow.
module audio_in_deserializer
  import audio_in_deserializer_pkg::*;
#(
  parameter int DATA_WIDTH = AUDIO_DATA_WIDTH,
  parameter int FIFO_DEPTH = AUDIO_FIFO_DEPTH
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                AUD_BCLK,
  input  logic                                AUD_ADCLRCK,
  input  logic                                AUD_ADCDAT,
  input  logic                                read_audio_in,
  input  logic                                clear_audio_in_memory,
  output logic                                audio_in_available,
  output logic [DATA_WIDTH-1:0]               left_channel_audio_in,
  output logic [DATA_WIDTH-1:0]               right_channel_audio_in,
  output logic [ptr_width(FIFO_DEPTH):0]      fifo_used,
  output logic                                overflow
);

  localparam int CNT_W = bit_cnt_width(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH);

  codec_pins_t pins_meta;
  codec_pins_t pins_sync;
  codec_pins_t pins_prev;
  logic        bclk_rise;
  logic        lrck_rise;
  logic        lrck_fall;

  logic [CNT_W-1:0]        bit_cnt;
  logic [DATA_WIDTH-1:0]   shift_reg;
  logic [DATA_WIDTH-1:0]   left_hold;
  logic                    left_valid;
  logic                    frame_started;

  logic                    pair_push;
  logic [2*DATA_WIDTH-1:0] pair_data;
  logic [2*DATA_WIDTH-1:0] head_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pins_meta <= '0;
      pins_sync <= '0;
      pins_prev <= '0;
    end else begin
      pins_meta <= '{bclk: AUD_BCLK, lrck: AUD_ADCLRCK, dat: AUD_ADCDAT};
      pins_sync <= pins_meta;
      pins_prev <= pins_sync;
    end
  end

  assign bclk_rise = pins_sync.bclk & ~pins_prev.bclk;
  assign lrck_rise = pins_sync.lrck & ~pins_prev.lrck;
  assign lrck_fall = ~pins_sync.lrck & pins_prev.lrck;

  // Count 0 is the I2S delay slot; counts 1..DATA_WIDTH land MSB-first, then the counter parks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else if (lrck_rise || lrck_fall) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else if (bclk_rise && (bit_cnt <= LAST_BIT)) begin
      if (bit_cnt != '0) begin
        shift_reg <= shift_reg | (DATA_WIDTH'(pins_sync.dat) << (LAST_BIT - bit_cnt));
      end
      bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

  // A left word is trusted only if its half-frame was seen from the opening LRCK fall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      left_hold     <= '0;
      left_valid    <= 1'b0;
      frame_started <= 1'b0;
    end else if (lrck_rise) begin
      left_hold  <= shift_reg;
      left_valid <= frame_started;
    end else if (lrck_fall) begin
      left_valid    <= 1'b0;
      frame_started <= 1'b1;
    end
  end

  assign pair_push = lrck_fall & left_valid;
  assign pair_data = {left_hold, shift_reg};

  audio_pair_fifo #(
    .WIDTH (2 * DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_pair_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear_audio_in_memory),
    .push      (pair_push),
    .push_data (pair_data),
    .pop       (read_audio_in),
    .head_data (head_data),
    .available (audio_in_available),
    .count     (fifo_used),
    .overflow  (overflow)
  );

  assign {left_channel_audio_in, right_channel_audio_in} = head_data;

endmodule

// File: tb/tb_audio_in_deserializer.sv
// Bench for audio_in_deserializer: table of stereo words plus FIFO/overflow/clear/reset sequences.
module tb_audio_in_deserializer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        AUD_BCLK;
  logic        AUD_ADCLRCK;
  logic        AUD_ADCDAT;
  logic        read_audio_in;
  logic        clear_audio_in_memory;
  logic        audio_in_available;
  logic [31:0] left_channel_audio_in;
  logic [31:0] right_channel_audio_in;
  logic [3:0]  fifo_used;
  logic        overflow;

  always #5 clk = ~clk;

  audio_in_deserializer #(
    .DATA_WIDTH (32),
    .FIFO_DEPTH (8)
  ) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .AUD_BCLK               (AUD_BCLK),
    .AUD_ADCLRCK            (AUD_ADCLRCK),
    .AUD_ADCDAT             (AUD_ADCDAT),
    .read_audio_in          (read_audio_in),
    .clear_audio_in_memory  (clear_audio_in_memory),
    .audio_in_available     (audio_in_available),
    .left_channel_audio_in  (left_channel_audio_in),
    .right_channel_audio_in (right_channel_audio_in),
    .fifo_used              (fifo_used),
    .overflow               (overflow)
  );

  typedef struct {
    logic [31:0] l;
    logic [31:0] r;
    int          nl;
    int          nr;
    int          extra;
    logic [31:0] el;
    logic [31:0] er;
  } vec_t;

  vec_t        vecs[6];
  logic [63:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_head(input string name);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, dut shows %0h", name,
               {left_channel_audio_in, right_channel_audio_in});
    end else begin
      e = exp_q.pop_front();
      check(name, {left_channel_audio_in, right_channel_audio_in}, e);
    end
  endtask

  task automatic pop_pulse();
    read_audio_in = 1'b1;
    @(negedge clk);
    read_audio_in = 1'b0;
  endtask

  task automatic wait_avail(input string name);
    int n = 0;
    while (!audio_in_available && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!audio_in_available) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout waiting for audio_in_available, got 0 expected 1", name);
    end
  endtask

  // One BCLK period = 16 clk; data changes while BCLK is low.
  task automatic bclk_bit(input logic d);
    @(negedge clk);
    AUD_BCLK   = 1'b0;
    AUD_ADCDAT = d;
    repeat (8) @(negedge clk);
    AUD_BCLK = 1'b1;
    repeat (7) @(negedge clk);
  endtask

  task automatic send_half(input logic lr, input logic [31:0] w, input int nbits, input int extra);
    logic [31:0] sh;
    sh = w;
    @(negedge clk);
    AUD_BCLK    = 1'b0;
    AUD_ADCLRCK = lr;
    AUD_ADCDAT  = 1'b0;
    repeat (8) @(negedge clk);
    AUD_BCLK = 1'b1;
    repeat (7) @(negedge clk);
    for (int i = 0; i < nbits; i++) bclk_bit(sh[31-i]);
    for (int i = 0; i < extra; i++) bclk_bit(1'b1);
  endtask

  task automatic send_pair(input logic [31:0] l, input logic [31:0] r,
                           input int nl, input int nr, input int extra);
    send_half(1'b0, l, nl, extra);
    send_half(1'b1, r, nr, extra);
  endtask

  // Drops LRCK to close the right word; optional pop/clear land exactly in the push cycle
  // (LRCK fall is seen after the 2-flop synchronizer, i.e. on the third rising edge).
  task automatic close_frame(input bit pop_in_push, input bit clear_in_push, input string name);
    @(negedge clk);
    AUD_BCLK    = 1'b0;
    AUD_ADCLRCK = 1'b0;
    AUD_ADCDAT  = 1'b0;
    repeat (2) @(negedge clk);
    if (pop_in_push) check_head(name);
    read_audio_in         = pop_in_push;
    clear_audio_in_memory = clear_in_push;
    @(negedge clk);
    read_audio_in         = 1'b0;
    clear_audio_in_memory = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_and_close(input logic [31:0] l, input logic [31:0] r, input bit expect_stored);
    if (expect_stored) exp_q.push_back({l, r});
    send_pair(l, r, 32, 32, 0);
    close_frame(1'b0, 1'b0, "close");
  endtask

  initial begin
    reset_n               = 1'b0;
    AUD_BCLK              = 1'b0;
    AUD_ADCLRCK           = 1'b0;
    AUD_ADCDAT            = 1'b0;
    read_audio_in         = 1'b0;
    clear_audio_in_memory = 1'b0;

    vecs[0] = '{32'h8000_0001, 32'h7FFF_FFFE, 32, 32, 0, 32'h8000_0001, 32'h7FFF_FFFE};
    vecs[1] = '{32'hFFFF_FFFF, 32'hC3C3_C3C3, 24, 24, 0, 32'hFFFF_FF00, 32'hC3C3_C300};
    vecs[2] = '{32'hA5A5_5A5A, 32'h1234_5678, 32, 32, 3, 32'hA5A5_5A5A, 32'h1234_5678};
    vecs[3] = '{32'hDEAD_BEEF, 32'h0F0F_0F0F, 16,  8, 0, 32'hDEAD_0000, 32'h0F00_0000};
    vecs[4] = '{32'h0000_0001, 32'h8000_0000, 32, 32, 0, 32'h0000_0001, 32'h8000_0000};
    vecs[5] = '{32'h1357_9BDF, 32'hFFFF_FFFF, 31,  1, 0, 32'h1357_9BDE, 32'h8000_0000};

    repeat (3) @(negedge clk);
    check("reset_available", audio_in_available, 1'b0);
    check("reset_used", fifo_used, 4'd0);
    check("reset_data", {left_channel_audio_in, right_channel_audio_in}, 64'd0);
    check("reset_overflow", overflow, 1'b0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Start mid right half-frame: nothing may be pushed until a full left then right.
    send_half(1'b1, 32'hFFFF_FFFF, 12, 0);

    for (int i = 0; i < 6; i++) begin
      exp_q.push_back({vecs[i].el, vecs[i].er});
      send_pair(vecs[i].l, vecs[i].r, vecs[i].nl, vecs[i].nr, vecs[i].extra);
      check($sformatf("vec%0d_no_early_push", i), fifo_used, 4'd0);
      close_frame(1'b0, 1'b0, "close");
      wait_avail($sformatf("vec%0d_avail", i));
      check($sformatf("vec%0d_used", i), fifo_used, 4'd1);
      check_head($sformatf("vec%0d_pair", i));
      pop_pulse();
      check($sformatf("vec%0d_empty_after_pop", i), {audio_in_available, fifo_used}, 5'd0);
      check($sformatf("vec%0d_zero_data", i), {left_channel_audio_in, right_channel_audio_in}, 64'd0);
    end

    // Nine pairs into a depth-8 FIFO: the ninth is lost.
    for (int k = 0; k < 9; k++) send_and_close(32'h1000_0000 + k, 32'h2000_0000 + k, k < 8);
    check("ovf_used", fifo_used, 4'd8);
    check("ovf_flag", overflow, 1'b1);
    check("ovf_head", {left_channel_audio_in, right_channel_audio_in}, exp_q[0]);
    for (int k = 0; k < 8; k++) begin
      check_head($sformatf("ovf_pop%0d", k));
      pop_pulse();
    end
    check("ovf_drained", {audio_in_available, fifo_used}, 5'd0);
    check("ovf_sticky", overflow, 1'b1);
    pop_pulse();
    check("pop_empty_ignored", fifo_used, 4'd0);

    // Clear with three stored pairs while a push and a pop hit the same cycle.
    for (int k = 0; k < 3; k++) send_and_close(32'h3000_0000 + k, 32'h4000_0000 + k, 1'b1);
    check("clr_used_before", fifo_used, 4'd3);
    exp_q.push_back({32'h3000_00FF, 32'h4000_00FF});
    send_pair(32'h3000_00FF, 32'h4000_00FF, 32, 32, 0);
    close_frame(1'b1, 1'b1, "clr_head");
    check("clr_used", fifo_used, 4'd0);
    check("clr_available", audio_in_available, 1'b0);
    check("clr_overflow", overflow, 1'b0);
    check("clr_data", {left_channel_audio_in, right_channel_audio_in}, 64'd0);
    exp_q.delete();

    send_and_close(32'hCAFE_F00D, 32'h0BAD_BEEF, 1'b1);
    wait_avail("post_clr_avail");
    check_head("post_clr_pair");
    pop_pulse();

    // Full FIFO with a pop in the push cycle: accepted, count stays 8, no overflow.
    for (int k = 0; k < 8; k++) send_and_close(32'h5000_0000 + k, 32'h6000_0000 + k, 1'b1);
    check("full_used", fifo_used, 4'd8);
    exp_q.push_back({32'h5000_0008, 32'h6000_0008});
    send_pair(32'h5000_0008, 32'h6000_0008, 32, 32, 0);
    close_frame(1'b1, 1'b0, "full_pop_head");
    check("full_pop_used", fifo_used, 4'd8);
    check("full_pop_overflow", overflow, 1'b0);
    for (int k = 0; k < 8; k++) begin
      check_head($sformatf("full_pop%0d", k));
      pop_pulse();
    end
    check("full_drained", fifo_used, 4'd0);

    // Reset mid left word with a pair stored: outputs clear at once, partial frame discarded.
    send_and_close(32'h7777_0000, 32'h8888_0000, 1'b1);
    check("rst_stored", fifo_used, 4'd1);
    send_half(1'b0, 32'hFFFF_FFFF, 10, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_async_used", fifo_used, 4'd0);
    check("rst_async_available", audio_in_available, 1'b0);
    check("rst_async_data", {left_channel_audio_in, right_channel_audio_in}, 64'd0);
    check("rst_async_overflow", overflow, 1'b0);
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    send_half(1'b0, 32'hFFFF_FFFF, 22, 0);
    send_half(1'b1, 32'h1111_1111, 32, 0);
    close_frame(1'b0, 1'b0, "close");
    check("rst_partial_dropped", fifo_used, 4'd0);
    send_and_close(32'h0123_4567, 32'h89AB_CDEF, 1'b1);
    wait_avail("rst_after_avail");
    check_head("rst_after_pair");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
